// File: rtl/axi_pkg.sv
// Shared AXI write-slave types and widths.
// Burst/response encodings, FSM states, AW legality check.
package axi_pkg;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int LEN_W  = 4;
  localparam int SIZE_W = 3;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_DATA = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // 1 when the AW request can never be serviced legally
  function automatic logic aw_bad(
    input logic [ADDR_W-1:0] addr,
    input logic [SIZE_W-1:0] size,
    input logic [LEN_W-1:0]  len,
    input logic [1:0]        burst
  );
    logic [13:0]       span;
    logic [13:0]       endb;
    logic [ADDR_W-1:0] amask;
    logic              wlen_ok;
    span    = ({10'd0, len} + 14'd1) << size;
    endb    = {2'b00, addr[11:0]} + span;
    amask   = (32'd1 << size) - 32'd1;
    wlen_ok = (len == 4'd1) || (len == 4'd3) ||
              (len == 4'd7) || (len == 4'd15);
    aw_bad  = 1'b0;
    if (burst == BURST_RSVD)
      aw_bad = 1'b1;
    if (size > 3'd2)
      aw_bad = 1'b1;
    if (burst == BURST_WRAP && !wlen_ok)
      aw_bad = 1'b1;
    if (burst == BURST_WRAP && (addr & amask) != '0)
      aw_bad = 1'b1;
    if (burst == BURST_INCR && endb > 14'd4096)
      aw_bad = 1'b1;
    return aw_bad;
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Next beat address for FIXED/INCR/WRAP bursts.
// Purely combinational; fed by the current beat address.
module axi_addr_gen
  import axi_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic [SIZE_W-1:0] size,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] aligned;
  logic [ADDR_W-1:0] wmask;
  logic [ADDR_W-1:0] base;

  // step from the aligned address; WRAP folds into its window
  always_comb begin
    bytes     = 32'd1 << size;
    aligned   = addr & ~(bytes - 32'd1);
    wmask     = (({28'd0, len} + 32'd1) << size) - 32'd1;
    base      = addr & ~wmask;
    next_addr = addr;
    unique case (1'b1)
      burst == BURST_INCR:
        next_addr = aligned + bytes;
      burst == BURST_WRAP:
        next_addr = base | ((aligned + bytes) & wmask);
      default:
        next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_wr_slave.sv
// Single-outstanding AXI write slave with memory strobe.
// IDLE -> DATA -> RESP; errors answered with SLVERR.
module axi_wr_slave
  import axi_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic [SIZE_W-1:0] AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ID_W-1:0]   WID,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic              resp_timeout
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  state_t            state;
  logic [ID_W-1:0]   aw_id;
  logic [LEN_W-1:0]  aw_len;
  logic [SIZE_W-1:0] aw_size;
  logic [1:0]        aw_burst;
  logic              aw_err;
  logic              beat_err;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] nxt_addr;
  logic [LEN_W-1:0]  cnt;
  logic [WW-1:0]     wcnt;

  logic is_last_cnt;
  logic wid_bad;
  logic last_bad;
  logic w_end;

  assign is_last_cnt = (cnt == aw_len);
  assign wid_bad     = (WID != aw_id);
  assign last_bad    = (WLAST != is_last_cnt);
  assign w_end       = WLAST || is_last_cnt;

  axi_addr_gen u_addr_gen (
    .addr      (cur_addr),
    .size      (aw_size),
    .len       (aw_len),
    .burst     (aw_burst),
    .next_addr (nxt_addr)
  );

  // transaction FSM with registered handshakes and outputs
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state        <= ST_IDLE;
      AWREADY      <= 1'b0;
      WREADY       <= 1'b0;
      BVALID       <= 1'b0;
      BID          <= '0;
      BRESP        <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      resp_timeout <= 1'b0;
      aw_id        <= '0;
      aw_len       <= '0;
      aw_size      <= '0;
      aw_burst     <= '0;
      aw_err       <= 1'b0;
      beat_err     <= 1'b0;
      cur_addr     <= '0;
      cnt          <= '0;
      wcnt         <= '0;
    end else begin
      mem_we       <= 1'b0;
      resp_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          AWREADY <= 1'b1;
          if (AWVALID && AWREADY) begin
            aw_id    <= AWID;
            aw_len   <= AWLEN;
            aw_size  <= AWSIZE;
            aw_burst <= AWBURST;
            aw_err   <= aw_bad(AWADDR, AWSIZE,
                               AWLEN, AWBURST);
            beat_err <= 1'b0;
            cur_addr <= AWADDR;
            cnt      <= '0;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b1;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (WVALID && WREADY) begin
            mem_we    <= !aw_err && !wid_bad;
            mem_addr  <= cur_addr;
            mem_wdata <= WDATA;
            mem_wstrb <= WSTRB;
            cur_addr  <= nxt_addr;
            cnt       <= cnt + 4'd1;
            if (wid_bad || last_bad)
              beat_err <= 1'b1;
            if (w_end) begin
              WREADY <= 1'b0;
              BVALID <= 1'b1;
              BID    <= aw_id;
              BRESP  <= (aw_err || beat_err ||
                         wid_bad || last_bad) ?
                        RESP_SLVERR : RESP_OKAY;
              wcnt   <= '0;
              state  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            if (wcnt < WW'(MAX_WAIT))
              wcnt <= wcnt + 1'b1;
            if (wcnt == WW'(MAX_WAIT - 1))
              resp_timeout <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_slave.sv
// Scoreboard bench for axi_wr_slave.
// Directed bursts; monitor pops expected mem writes and B responses.
module tb_axi_wr_slave;

  localparam int MAX_WAIT = 16;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [3:0]  WID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        resp_timeout;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } mem_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_t;

  mem_t exp_mem[$];
  b_t   exp_b[$];

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int pulses = 0;

  logic [31:0] ea [4];

  axi_wr_slave #(.MAX_WAIT(MAX_WAIT)) dut (
    .ACLK         (ACLK),
    .ARESETn      (ARESETn),
    .AWID         (AWID),
    .AWADDR       (AWADDR),
    .AWLEN        (AWLEN),
    .AWSIZE       (AWSIZE),
    .AWBURST      (AWBURST),
    .AWVALID      (AWVALID),
    .AWREADY      (AWREADY),
    .WID          (WID),
    .WDATA        (WDATA),
    .WSTRB        (WSTRB),
    .WLAST        (WLAST),
    .WVALID       (WVALID),
    .WREADY       (WREADY),
    .BID          (BID),
    .BRESP        (BRESP),
    .BVALID       (BVALID),
    .BREADY       (BREADY),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .resp_timeout (resp_timeout)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // scoreboard monitor for memory writes and B handshakes
  always @(negedge ACLK) begin
    if (mem_we) begin
      if (exp_mem.size() == 0) begin
        chk("unexpected_mem_we", mem_addr, 32'hFFFF_FFFF);
      end else begin
        mem_t m;
        m = exp_mem.pop_front();
        chk("mem_addr", mem_addr, m.addr);
        chk("mem_wdata", mem_wdata, m.data);
        chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, m.strb});
      end
    end
    if (BVALID && BREADY) begin
      if (exp_b.size() == 0) begin
        chk("unexpected_b", {28'd0, BID}, 32'hFFFF_FFFF);
      end else begin
        b_t b;
        b = exp_b.pop_front();
        chk("bid", {28'd0, BID}, {28'd0, b.id});
        chk("bresp", {30'd0, BRESP}, {30'd0, b.resp});
      end
    end
  end

  // response stall watcher: pulse only after MAX_WAIT stalled cycles
  always @(negedge ACLK) begin
    if (resp_timeout || stalls == MAX_WAIT)
      chk("resp_timeout", {31'd0, resp_timeout},
          {31'd0, stalls == MAX_WAIT});
    if (resp_timeout)
      pulses++;
    if (!ARESETn || !BVALID)
      stalls = 0;
    else if (!BREADY)
      stalls++;
  end

  task automatic do_aw(input logic [3:0] id,
                       input logic [31:0] addr,
                       input logic [3:0] len,
                       input logic [2:0] size,
                       input logic [1:0] burst);
    logic ok;
    AWID = id; AWADDR = addr; AWLEN = len;
    AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (AWREADY) begin
        ok = 1'b1;
        break;
      end
    end
    chk("aw_accept", {31'd0, ok}, 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
  endtask

  task automatic w_beat(input logic [3:0] id,
                        input logic [31:0] data,
                        input logic [3:0] strb,
                        input logic last,
                        input logic we,
                        input logic [31:0] addr);
    logic ok;
    if (we)
      exp_mem.push_back('{addr: addr, data: data, strb: strb});
    WID = id; WDATA = data; WSTRB = strb;
    WLAST = last; WVALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (WREADY) begin
        ok = 1'b1;
        break;
      end
    end
    chk("w_accept", {31'd0, ok}, 32'd1);
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    WLAST = 1'b0;
  endtask

  task automatic push_b(input logic [3:0] id,
                        input logic [1:0] resp);
    exp_b.push_back('{id: id, resp: resp});
  endtask

  task automatic wait_b();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ACLK);
      if (BVALID && BREADY) begin
        ok = 1'b1;
        break;
      end
    end
    chk("b_done", {31'd0, ok}, 32'd1);
    @(posedge ACLK); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_awready"}, {31'd0, AWREADY}, 32'd0);
    chk({tag, "_wready"}, {31'd0, WREADY}, 32'd0);
    chk({tag, "_bvalid"}, {31'd0, BVALID}, 32'd0);
    chk({tag, "_bid"}, {28'd0, BID}, 32'd0);
    chk({tag, "_bresp"}, {30'd0, BRESP}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
    chk({tag, "_timeout"}, {31'd0, resp_timeout}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0;
    AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WID = '0; WDATA = '0; WSTRB = '0;
    WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk_zero("reset");
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("awready_first", {31'd0, AWREADY}, 32'd0);
    @(negedge ACLK);
    chk("awready_second", {31'd0, AWREADY}, 32'd1);
    @(posedge ACLK); #1;

    // INCR 0x100, 4 beats
    ea = '{32'h100, 32'h104, 32'h108, 32'h10C};
    push_b(4'd5, 2'b00);
    do_aw(4'd5, 32'h100, 4'd3, 3'd2, 2'b01);
    AWVALID = 1'b1;
    @(negedge ACLK);
    chk("awready_in_data", {31'd0, AWREADY}, 32'd0);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int i = 0; i < 4; i++)
      w_beat(4'd5, 32'hD100_0000 + i, 4'hF, i == 3, 1'b1, ea[i]);
    wait_b();

    // WRAP 0x108, wraps to window base 0x100
    ea = '{32'h108, 32'h10C, 32'h100, 32'h104};
    push_b(4'd1, 2'b00);
    do_aw(4'd1, 32'h108, 4'd3, 3'd2, 2'b10);
    for (int i = 0; i < 4; i++)
      w_beat(4'd1, 32'hD200_0000 + i, 4'h3, i == 3, 1'b1, ea[i]);
    wait_b();

    // INCR crossing 4KB: beats taken, no writes
    push_b(4'd2, 2'b10);
    do_aw(4'd2, 32'hFF8, 4'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++)
      w_beat(4'd2, 32'hD300_0000 + i, 4'hF, i == 3, 1'b0, 32'd0);
    wait_b();

    // reserved burst, single beat
    push_b(4'd8, 2'b10);
    do_aw(4'd8, 32'h10, 4'd0, 3'd2, 2'b11);
    w_beat(4'd8, 32'hD400_0000, 4'hF, 1'b1, 1'b0, 32'd0);
    wait_b();

    // early WLAST on beat 1 of 4
    push_b(4'd3, 2'b10);
    do_aw(4'd3, 32'h200, 4'd3, 3'd2, 2'b01);
    w_beat(4'd3, 32'hD500_0000, 4'hF, 1'b0, 1'b1, 32'h200);
    w_beat(4'd3, 32'hD500_0001, 4'hF, 1'b1, 1'b1, 32'h204);
    wait_b();
    WVALID = 1'b1; WID = 4'd3; WDATA = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("wready_idle", {31'd0, WREADY}, 32'd0);
    end
    @(posedge ACLK); #1;
    WVALID = 1'b0;

    // WID mismatch on first beat only
    push_b(4'd2, 2'b10);
    do_aw(4'd2, 32'h400, 4'd1, 3'd2, 2'b01);
    w_beat(4'd3, 32'hD600_0000, 4'hF, 1'b0, 1'b0, 32'd0);
    w_beat(4'd2, 32'hD600_0001, 4'hC, 1'b1, 1'b1, 32'h404);
    wait_b();

    // late WLAST: count reaches AWLEN without WLAST
    push_b(4'd4, 2'b10);
    do_aw(4'd4, 32'h480, 4'd1, 3'd2, 2'b01);
    w_beat(4'd4, 32'hD700_0000, 4'hF, 1'b0, 1'b1, 32'h480);
    w_beat(4'd4, 32'hD700_0001, 4'hF, 1'b0, 1'b1, 32'h484);
    wait_b();

    // FIXED halfword bursts stay on one address
    push_b(4'd6, 2'b00);
    do_aw(4'd6, 32'h40, 4'd2, 3'd1, 2'b00);
    for (int i = 0; i < 3; i++)
      w_beat(4'd6, 32'hD800_0000 + i, 4'h3, i == 2, 1'b1, 32'h40);
    wait_b();

    // INCR unaligned start
    ea = '{32'h102, 32'h104, 32'h108, 32'h0};
    push_b(4'd7, 2'b00);
    do_aw(4'd7, 32'h102, 4'd2, 3'd2, 2'b01);
    for (int i = 0; i < 3; i++)
      w_beat(4'd7, 32'hD900_0000 + i, 4'hF, i == 2, 1'b1, ea[i]);
    wait_b();

    // WRAP with illegal length
    push_b(4'd3, 2'b10);
    do_aw(4'd3, 32'h100, 4'd2, 3'd2, 2'b10);
    for (int i = 0; i < 3; i++)
      w_beat(4'd3, 32'hDA00_0000 + i, 4'hF, i == 2, 1'b0, 32'd0);
    wait_b();

    // response stall of 20 cycles
    BREADY = 1'b0;
    pulses = 0;
    push_b(4'd9, 2'b00);
    do_aw(4'd9, 32'h300, 4'd0, 3'd2, 2'b01);
    w_beat(4'd9, 32'hDB00_0000, 4'hF, 1'b1, 1'b1, 32'h300);
    begin
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (BVALID) begin
          ok = 1'b1;
          break;
        end
        @(negedge ACLK);
      end
      chk("bvalid_seen", {31'd0, ok}, 32'd1);
    end
    for (int i = 0; i < 20; i++) begin
      chk("stall_bvalid", {31'd0, BVALID}, 32'd1);
      chk("stall_bid", {28'd0, BID}, 32'd9);
      chk("stall_bresp", {30'd0, BRESP}, 32'd0);
      @(negedge ACLK);
    end
    chk("timeout_pulses", pulses, 32'd1);
    @(posedge ACLK); #1;
    BREADY = 1'b1;
    wait_b();

    // reset after beat 2 of 4
    do_aw(4'd5, 32'h500, 4'd3, 3'd2, 2'b01);
    w_beat(4'd5, 32'hDC00_0000, 4'hF, 1'b0, 1'b1, 32'h500);
    w_beat(4'd5, 32'hDC00_0001, 4'hF, 1'b0, 1'b1, 32'h504);
    ARESETn = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    chk_zero("midreset");
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);
    chk("bvalid_after_reset", {31'd0, BVALID}, 32'd0);
    @(posedge ACLK); #1;
    push_b(4'd1, 2'b00);
    do_aw(4'd1, 32'h600, 4'd0, 3'd2, 2'b01);
    w_beat(4'd1, 32'hDD00_0000, 4'h1, 1'b1, 1'b1, 32'h600);
    wait_b();

    repeat (5) @(negedge ACLK);
    chk("mem_queue_empty", exp_mem.size(), 32'd0);
    chk("b_queue_empty", exp_b.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
